// File: rtl/if_pkg.sv
// Shared types for the instruction fetch front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

    // Struct field widths; the fetch unit's ADDR_WIDTH/INSTR_WIDTH must match these.
    localparam int IF_ADDR_W   = 64;
    localparam int IF_INSTR_W  = 32;
    localparam int INSTR_BYTES = 4;

    // Buffered instruction handed to decode.
    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } if_entry_t;

    // Outstanding memory request: its PC and the epoch it was issued in.
    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic                 epoch;
    } inflight_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO of type T with flush and occupancy count.
// Latency: push visible at pop_data the cycle after the push edge; head read is combinational.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fetch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              pop_data,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Pointer and count update; flush discards everything and beats a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: issues imem requests at pc_reg, buffers in-order responses for decode.
// Latency: request combinational from pc_reg; response reaches id_* one cycle after capture.
// Backpressure: credits (inflight + buffered < FIFO_DEPTH) gate issue; stall holds the PC register.
// Optional: define IF_FETCH_PERF_EN to add saturating stall/dropped-response counters.
import if_pkg::*;

module if_fetch_unit #(
    parameter int                    ADDR_WIDTH  = IF_ADDR_W,
    parameter int                    INSTR_WIDTH = IF_INSTR_W,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_reg,
    output logic [ADDR_WIDTH-1:0]  pc_next,
    output logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_dropped_rsp
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] out_count;
    logic          epoch;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_keep;
    logic          id_fire;
    inflight_t     inflight_push;
    inflight_t     inflight_head;
    if_entry_t     out_push;
    if_entry_t     out_head;

    // Registered counts only: a same-cycle decode pop does not free a credit.
    assign credit_ok      = ({1'b0, inflight_cnt} + {1'b0, out_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_next        = redirect_valid ? redirect_pc : pc_reg + ADDR_WIDTH'(INSTR_BYTES);
    assign stall          = !redirect_valid && !req_fire;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = imem_rsp_valid && (inflight_cnt != '0);
    assign rsp_keep = rsp_take && (inflight_head.epoch == epoch);
    assign id_valid = (out_count != '0);
    assign id_fire  = id_valid && id_ready;
    assign id_instr = id_valid ? out_head.instr : '0;
    assign id_pc    = id_valid ? out_head.pc    : '0;

    assign inflight_push = '{pc: pc_reg, epoch: epoch};
    assign out_push      = '{pc: inflight_head.pc, instr: imem_rsp_data};

    // Each redirect starts a new epoch so older responses can be recognised and dropped.
    always_ff @(posedge clk) begin
        if (reset)               epoch <= 1'b0;
        else if (redirect_valid) epoch <= ~epoch;
    end

    // In-flight queue is never flushed; stale entries drain as their responses return.
    fetch_fifo #(.T(inflight_t), .DEPTH(FIFO_DEPTH)) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (inflight_push),
        .pop       (rsp_take),
        .pop_data  (inflight_head),
        .count     (inflight_cnt)
    );

    // Output buffer; a redirect flush wins over a same-cycle push and pop.
    fetch_fifo #(.T(if_entry_t), .DEPTH(FIFO_DEPTH)) u_out (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (out_push),
        .pop       (id_fire),
        .pop_data  (out_head),
        .count     (out_count)
    );

`ifdef IF_FETCH_PERF_EN
    // Saturating counters of stalled cycles and stale responses dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_dropped_rsp  <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (rsp_take && (inflight_head.epoch != epoch) && (perf_dropped_rsp != '1))
                perf_dropped_rsp <= perf_dropped_rsp + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    logic rst_d;

    // Remember reset so the first post-reset PC can be checked against RESET_ADDR.
    always_ff @(posedge clk) begin
        rst_d <= reset;
    end

    // Protocol checks: no unsolicited responses, and the PC register must agree on its reset value.
    always_ff @(posedge clk) begin
        if (!reset && imem_rsp_valid)
            assert (inflight_cnt != '0) else $error("imem response with no request outstanding");
        if (!reset && rst_d)
            assert (pc_reg == RESET_ADDR) else $error("pc_reg differs from RESET_ADDR after reset");
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table for PC/issue logic, scoreboarded streaming sequences.
// Latency: memory model answers after a programmable number of cycles.
// Backpressure: exercised through imem_req_ready and id_ready.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dropped_rsp;
`endif

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_reg         (pc_reg),
        .pc_next        (pc_next),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dropped_rsp  (perf_dropped_rsp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: bench-driven in the vector phase, self-updating otherwise.
    logic        pc_auto;
    logic [63:0] pc_man;
    logic [63:0] pc_q;
    assign pc_reg = pc_auto ? pc_q : pc_man;

    always @(posedge clk) begin
        if (reset)       pc_q <= 64'h0;
        else if (!stall) pc_q <= pc_next;
    end

    typedef struct {
        logic [63:0] pc;
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic [63:0] exp_next;
        logic        exp_vld;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          gen;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t  vecs [6];
    mreq_t mem_q [$];
    exp_t  exp_q [$];
    int    checks;
    int    failures;
    int    cyc;
    int    gen;
    int    lat;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory + decode model, evaluated at the negative edge for the coming rising edge.
    task automatic model();
        exp_t  e;
        mreq_t m;
        if (reset) begin
            exp_q.delete();
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            return;
        end
        if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_decode_output", 64'h1, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_instr", {32'h0, id_instr}, {32'h0, e.instr});
            end
        end
        if (redirect_valid) begin
            gen++;
            exp_q.delete();
        end
        if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{addr: imem_req_addr, gen: gen, due: cyc + 1 + lat});
        imem_rsp_valid = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(m.addr);
            if (m.gen == gen) exp_q.push_back('{pc: m.addr, instr: instr_of(m.addr)});
        end
    endtask

    // One clock: model at negedge, then return 1 time unit after the rising edge.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            model();
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    initial begin
        logic [63:0] hold;
        bit          seen;
        checks = 0; failures = 0; cyc = 0; gen = 0; lat = 1;
        vecs[0] = '{64'h0,                  1'b0, 64'h0,    1'b1, 64'h4,           1'b1, 1'b0};
        vecs[1] = '{64'h100,                1'b0, 64'h0,    1'b0, 64'h104,         1'b1, 1'b1};
        vecs[2] = '{64'h100,                1'b1, 64'h2000, 1'b1, 64'h2000,        1'b0, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,    1'b1, 64'h0,           1'b1, 1'b0};
        vecs[4] = '{64'h7FFF_FFFC,          1'b0, 64'h0,    1'b0, 64'h8000_0000,   1'b1, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h40,   1'b0, 64'h40,          1'b0, 1'b0};

        reset = 1'b1; pc_auto = 1'b0; pc_man = 64'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
        cycle(2);
        #3;
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("rst_stall", {63'h0, stall}, 64'h1);
        check("rst_id_pc", id_pc, 64'h0);
        check("rst_id_instr", {32'h0, id_instr}, 64'h0);
        check("rst_inflight", 64'(dut.inflight_cnt), 64'h0);
        check("rst_out_count", 64'(dut.out_count), 64'h0);
        check("rst_epoch", {63'h0, dut.epoch}, 64'h0);

        // Vector table: combinational PC/issue logic, inputs reverted before the edge.
        reset = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) begin
            pc_man = vecs[i].pc; redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc; imem_req_ready = vecs[i].rdy;
            #3;
            check($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].exp_next);
            check($sformatf("vec%0d_req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].exp_vld});
            check($sformatf("vec%0d_stall", i), {63'h0, stall}, {63'h0, vecs[i].exp_stall});
            check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].pc);
            redirect_valid = 1'b0; imem_req_ready = 1'b0; pc_man = 64'h0;
            cycle();
        end

        // Streaming at one instruction per cycle with 1-cycle memory.
        reset = 1'b1;
        cycle();
        reset = 1'b0; pc_auto = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1; lat = 1;
        for (int i = 0; i < 7; i++) begin
            #3;
            check($sformatf("stream%0d_stall", i), {63'h0, stall}, 64'h0);
            if (i >= 2) begin
                check($sformatf("stream%0d_id_valid", i), {63'h0, id_valid}, 64'h1);
                check($sformatf("stream%0d_id_pc", i), id_pc, 64'(4 * (i - 2)));
            end
            cycle();
        end

        // Memory not ready for 3 cycles: stall, PC held.
        imem_req_ready = 1'b0;
        hold = pc_reg;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("nrdy%0d_stall", i), {63'h0, stall}, 64'h1);
            check($sformatf("nrdy%0d_addr", i), imem_req_addr, hold);
            check($sformatf("nrdy%0d_pc_next", i), pc_next, hold + 64'h4);
            cycle();
        end
        imem_req_ready = 1'b1;
        #3;
        check("nrdy_resume_stall", {63'h0, stall}, 64'h0);
        cycle();

        // Decode backpressure: credits cap outstanding + buffered at 4.
        id_ready = 1'b0;
        cycle(8);
        #3;
        check("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("bp_out_count", 64'(dut.out_count), 64'h4);
        check("bp_inflight", 64'(dut.inflight_cnt), 64'h0);
        check("bp_id_valid", {63'h0, id_valid}, 64'h1);
        id_ready = 1'b1;
        cycle();
        #3;
        check("bp_resume_req_valid", {63'h0, imem_req_valid}, 64'h1);

        // Redirect with two requests in flight.
        imem_req_ready = 1'b0;
        cycle(8);
        lat = 3;
        redirect_valid = 1'b1; redirect_pc = 64'h100; imem_req_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        cycle(2);
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        #3;
        check("redir_inflight", 64'(dut.inflight_cnt), 64'h2);
        check("redir_id_valid", {63'h0, id_valid}, 64'h0);
        cycle();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #3;
            if (id_valid) begin
                seen = 1'b1;
                check("redir_first_id_pc", id_pc, 64'h2000);
            end else begin
                cycle();
            end
        end
        if (!seen) check("redir_first_id_valid_timeout", 64'h0, 64'h1);
`ifdef IF_FETCH_PERF_EN
        check("perf_dropped", {32'h0, perf_dropped_rsp}, 64'h2);
`endif

        // Reset with 3 entries buffered.
        imem_req_ready = 1'b0; lat = 1;
        cycle(8);
        id_ready = 1'b0; imem_req_ready = 1'b1;
        cycle(3);
        imem_req_ready = 1'b0;
        cycle(3);
        #3;
        check("prerst_out_count", 64'(dut.out_count), 64'h3);
        check("prerst_id_valid", {63'h0, id_valid}, 64'h1);
        reset = 1'b1;
        cycle();
        #3;
        check("midrst_id_valid", {63'h0, id_valid}, 64'h0);
        check("midrst_inflight", 64'(dut.inflight_cnt), 64'h0);
        check("midrst_out_count", 64'(dut.out_count), 64'h0);
        check("midrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
